// File: rtl/fixed_to_float_if.sv
// Operand/result bundle for the fixed-to-float custom instruction.
// Handshake: the master raises start for one cycle with dataa valid; the request
// is taken only on a clock edge where clk_en=1 and the block sits in IDLE.
// The block answers with a one-enabled-cycle done pulse, and result is valid
// from that cycle until the next accepted request completes. Every cycle with
// clk_en=0 freezes the block, so a pending done stays visible until the next
// enabled edge.
interface fixed_to_float_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    modport master (
        output clk_en, start, dataa,
        input  done, result, dbg_state
    );

    modport slave (
        input  clk_en, start, dataa,
        output done, result, dbg_state
    );
endinterface

// File: rtl/fixed_to_float.sv
// Multicycle signed fixed-point to IEEE-754 single-precision converter.
// The magnitude is normalised one bit per clock, then rounded to nearest-even.
module fixed_to_float #(
    parameter int FRAC_BITS = 30
) (
    input  logic             clock,
    input  logic             aclr,
    fixed_to_float_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } state_t;

    // Exponent of the value when the fixed-point LSB is weighted 2^-FRAC_BITS
    // and the leading one would sit at bit 31.
    localparam logic [7:0] E_INIT = 8'(127 + 31 - FRAC_BITS);

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic [31:0] m_q, m_d;
    logic [7:0]  e_q, e_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic [23:0] mant;
    logic        round_up;
    logic [24:0] mant_sum;
    logic [23:0] mant_rnd;
    logic [7:0]  e_rnd;

    // Round-to-nearest-even of the normalised magnitude, used in ROUND.
    always_comb begin
        mant     = m_q[31:8];
        round_up = m_q[7] & ((|m_q[6:0]) | mant[0]);
        mant_sum = {1'b0, mant} + 25'(round_up);
        mant_rnd = mant_sum[23:0];
        e_rnd    = e_q;
        if (mant_sum[24]) begin
            mant_rnd = 24'h800000;
            e_rnd    = e_q + 8'd1;
        end
    end

    // Next-state and datapath update for the IDLE/NORM/ROUND sequence.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        m_d      = m_q;
        e_d      = e_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.dataa == 32'h0) begin
                        // Zero has no leading one; answer +0.0 immediately.
                        result_d = 32'h0;
                        done_d   = 1'b1;
                    end else begin
                        s_d     = bus.dataa[31];
                        m_d     = bus.dataa[31] ? (~bus.dataa + 32'd1) : bus.dataa;
                        e_d     = E_INIT;
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (m_q[31]) begin
                    state_d = ROUND;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - 8'd1;
                end
            end
            ROUND: begin
                result_d = {s_q, e_rnd, mant_rnd[22:0]};
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; frozen whenever the processor withholds clk_en.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q  <= IDLE;
            s_q      <= 1'b0;
            m_q      <= 32'h0;
            e_q      <= 8'h0;
            done_q   <= 1'b0;
            result_q <= 32'h0;
        end else if (bus.clk_en) begin
            state_q  <= state_d;
            s_q      <= s_d;
            m_q      <= m_d;
            e_q      <= e_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// Self-checking bench for fixed_to_float with FRAC_BITS=30.
module tb_fixed_to_float;

    localparam int FRAC = 30;

    logic clock;
    logic aclr;
    fixed_to_float_if bus ();

    fixed_to_float #(.FRAC_BITS(FRAC)) dut (
        .clock (clock),
        .aclr  (aclr),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic last_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: leading-one search plus explicit remainder-vs-half rounding.
    function automatic void model(input logic [31:0] d, output logic [31:0] f, output int lat);
        logic        s;
        logic [63:0] mag, mant, rem, half;
        int          p, sh, ex;
        if (d == 32'h0) begin
            f   = 32'h0;
            lat = 0;
            return;
        end
        s   = d[31];
        mag = s ? 64'(32'(-d)) : 64'(d);
        p   = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        lat = (31 - p) + 2;
        ex  = p - FRAC + 127;
        if (p <= 23) begin
            mant = mag << (23 - p);
        end else begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
            if (mant == (64'd1 << 24)) begin
                mant = mant >> 1;
                ex   = ex + 1;
            end
        end
        f = {s, 8'(ex), mant[22:0]};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(posedge clock) last_en = bus.clk_en;

    always @(negedge clock) begin
        if (!aclr && bus.done && last_en) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 32'd1, 32'd0);
            end else begin
                check_eq("result", bus.result, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one request at the current negedge, returns at the negedge where
    // done is seen, and checks the number of edges since acceptance.
    task automatic issue(input logic [31:0] d, input logic [31:0] exp_res, input int exp_lat);
        int k;
        bus.start = 1'b1;
        bus.dataa = d;
        exp_q.push_back(exp_res);
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 60) begin
            k++;
            @(negedge clock);
        end
        check_eq("latency", 32'(k), 32'(exp_lat));
    endtask

    task automatic issue_model(input logic [31:0] d);
        logic [31:0] f;
        int          lat;
        model(d, f, lat);
        issue(d, f, lat);
    endtask

    initial begin
        logic [31:0] r;
        aclr       = 1'b1;
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        bus.dataa  = 32'h0;
        repeat (3) @(negedge clock);
        check_eq("reset_done", 32'(bus.done), 32'd0);
        check_eq("reset_result", bus.result, 32'h0);
        check_eq("reset_state", 32'(bus.dbg_state), 32'd0);
        aclr = 1'b0;
        @(negedge clock);

        // Directed values with hand-derived results.
        issue(32'h40000000, 32'h3F800000, 3);
        @(negedge clock);
        issue(32'hC0000000, 32'hBF800000, 3);
        @(negedge clock);
        issue(32'h80000000, 32'hC0000000, 2);
        @(negedge clock);
        issue(32'h00000001, 32'h30800000, 33);
        @(negedge clock);
        issue(32'h00000000, 32'h00000000, 0);
        @(negedge clock);
        issue(32'h40000040, 32'h3F800000, 3);
        @(negedge clock);
        issue(32'h400000C0, 32'h3F800002, 3);
        @(negedge clock);
        issue(32'h7FFFFFFF, 32'h40000000, 3);

        // Back-to-back: next start in the cycle done is high.
        issue(32'h40000000, 32'h3F800000, 3);
        issue(32'hC0000000, 32'hBF800000, 3);
        issue(32'h00000000, 32'h00000000, 0);
        issue(32'h00000000, 32'h00000000, 0);
        issue(32'h80000000, 32'hC0000000, 2);
        @(negedge clock);

        // Stalls: start ignored in NORM, clk_en low mid-NORM and with done high.
        bus.start = 1'b1;
        bus.dataa = 32'h40000000;
        exp_q.push_back(32'h3F800000);
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.dataa = 32'hC0000000;
        @(negedge clock);
        bus.start  = 1'b0;
        bus.clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("stall_norm_done", 32'(bus.done), 32'd0);
        end
        bus.clk_en = 1'b1;
        @(negedge clock);
        check_eq("stall_done_late", 32'(bus.done), 32'd1);
        bus.clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("stall_done_hold", 32'(bus.done), 32'd1);
            check_eq("stall_result_hold", bus.result, 32'h3F800000);
        end
        bus.clk_en = 1'b1;
        @(negedge clock);
        check_eq("done_clears", 32'(bus.done), 32'd0);
        check_eq("result_kept", bus.result, 32'h3F800000);
        check_eq("ignored_start_idle", 32'(bus.dbg_state), 32'd0);

        // Asynchronous abort mid-NORM.
        bus.start = 1'b1;
        bus.dataa = 32'h00000001;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        #2 aclr = 1'b1;
        #1;
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_result", bus.result, 32'h0);
        check_eq("abort_state", 32'(bus.dbg_state), 32'd0);
        @(negedge clock);
        aclr = 1'b0;
        @(negedge clock);
        issue(32'h40000000, 32'h3F800000, 3);
        @(negedge clock);

        // Random operands, a mix of full-range and small magnitudes.
        for (int i = 0; i < 30; i++) begin
            r = $urandom;
            if ($urandom_range(0, 1) == 1) r = r >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) r = -r;
            issue_model(r);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
